// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_ctrl
// Brief   : MEM stage of the MIPS pipe; runs single-outstanding ack-based data-bus
//           transactions for loads/stores and passes all other ops to MEM/WB.
// Revision: 1.0 - initial release
// ============================================================================
module mem_bus_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic        whilo_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic        stall_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic [31:0] wdata_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_sel_o,
    output logic        bus_we_o,
    output logic        bus_cyc_o,
    output logic        stallreq_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam logic [7:0] C_OP_LB  = 8'b1110_0000;
    localparam logic [7:0] C_OP_LH  = 8'b1110_0001;
    localparam logic [7:0] C_OP_LW  = 8'b1110_0011;
    localparam logic [7:0] C_OP_LBU = 8'b1110_0100;
    localparam logic [7:0] C_OP_LHU = 8'b1110_0101;
    localparam logic [7:0] C_OP_SB  = 8'b1110_1000;
    localparam logic [7:0] C_OP_SH  = 8'b1110_1001;
    localparam logic [7:0] C_OP_SW  = 8'b1110_1011;

    localparam int              C_CW         = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [C_CW-1:0] C_TIMEOUT    = C_CW'(TIMEOUT_CYCLES);
    localparam bit              C_TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [C_CW-1:0]   r_cnt;
    logic [31:0]       r_rbuf;
    logic              r_err;
    logic              r_bus_err;
    logic [31:0]       r_bus_addr;
    logic [31:0]       r_bus_wdata;
    logic [3:0]        r_bus_sel;
    logic              r_bus_we;
    logic              r_bus_cyc;

    logic              w_is_load;
    logic              w_is_store;
    logic              w_is_byte;
    logic              w_is_half;
    logic              w_sign;
    logic              w_is_mem;
    logic              w_misaligned;
    logic              w_go;
    logic [3:0]        w_sel;
    logic [31:0]       w_store_data;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_data;
    logic [C_CW-1:0]   w_cnt_next;

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_is_byte  = 1'b0;
        w_is_half  = 1'b0;
        w_sign     = 1'b0;
        case (aluop_i)
            C_OP_LB:  begin w_is_load  = 1'b1; w_is_byte = 1'b1; w_sign = 1'b1; end
            C_OP_LBU: begin w_is_load  = 1'b1; w_is_byte = 1'b1; end
            C_OP_LH:  begin w_is_load  = 1'b1; w_is_half = 1'b1; w_sign = 1'b1; end
            C_OP_LHU: begin w_is_load  = 1'b1; w_is_half = 1'b1; end
            C_OP_LW:  begin w_is_load  = 1'b1; end
            C_OP_SB:  begin w_is_store = 1'b1; w_is_byte = 1'b1; end
            C_OP_SH:  begin w_is_store = 1'b1; w_is_half = 1'b1; end
            C_OP_SW:  begin w_is_store = 1'b1; end
            default:  ;
        endcase
    end

    assign w_is_mem     = w_is_load | w_is_store;
    assign w_misaligned = (w_is_half & mem_addr_i[0]) |
                          (~w_is_byte & ~w_is_half & (|mem_addr_i[1:0]));
    assign w_go         = w_is_mem & ~w_misaligned;
    assign w_cnt_next   = r_cnt + 1'b1;

    // Big-endian lanes: byte address 0 lives in bits [31:24]
    always_comb begin
        if (w_is_byte) begin
            w_sel        = 4'b1000 >> mem_addr_i[1:0];
            w_store_data = {4{reg2_i[7:0]}};
        end else if (w_is_half) begin
            w_sel        = mem_addr_i[1] ? 4'b0011 : 4'b1100;
            w_store_data = {2{reg2_i[15:0]}};
        end else begin
            w_sel        = 4'b1111;
            w_store_data = reg2_i;
        end
    end

    always_comb begin
        case (mem_addr_i[1:0])
            2'b00:   w_byte = r_rbuf[31:24];
            2'b01:   w_byte = r_rbuf[23:16];
            2'b10:   w_byte = r_rbuf[15:8];
            default: w_byte = r_rbuf[7:0];
        endcase
        w_half = mem_addr_i[1] ? r_rbuf[15:0] : r_rbuf[31:16];
        if (w_is_byte)
            w_load_data = {{24{w_sign & w_byte[7]}}, w_byte};
        else if (w_is_half)
            w_load_data = {{16{w_sign & w_half[15]}}, w_half};
        else
            w_load_data = r_rbuf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rbuf      <= '0;
            r_err       <= 1'b0;
            r_bus_err   <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_sel   <= '0;
            r_bus_we    <= 1'b0;
            r_bus_cyc   <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_bus_addr  <= {mem_addr_i[31:2], 2'b00};
                        r_bus_wdata <= w_store_data;
                        r_bus_sel   <= w_sel;
                        r_bus_we    <= w_is_store;
                        r_bus_cyc   <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (bus_ack_i) begin
                        r_rbuf    <= bus_rdata_i;
                        r_bus_cyc <= 1'b0;
                        r_state   <= S_DONE;
                    end else if (C_TIMEOUT_EN && (w_cnt_next == C_TIMEOUT)) begin
                        r_rbuf    <= '0;
                        r_bus_cyc <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_err     <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                S_DONE: begin
                    if (!stall_i) begin
                        r_err   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Pipeline-facing outputs are forced to zero while reset is held
    always_comb begin
        wdata_o    = wdata_i;
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        whilo_o    = whilo_i;
        hi_o       = hi_i;
        lo_o       = lo_i;
        stallreq_o = 1'b0;
        misalign_o = 1'b0;
        if (w_is_mem) begin
            wreg_o = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_misaligned)
                        misalign_o = 1'b1;
                    else
                        stallreq_o = 1'b1;
                end
                S_BUSY: stallreq_o = 1'b1;
                S_DONE: begin
                    if (w_is_load) begin
                        wdata_o = w_load_data;
                        wreg_o  = wreg_i & ~r_err;
                    end
                end
                default: ;
            endcase
        end
        if (!rst_n) begin
            wdata_o    = '0;
            wd_o       = '0;
            wreg_o     = 1'b0;
            whilo_o    = 1'b0;
            hi_o       = '0;
            lo_o       = '0;
            stallreq_o = 1'b0;
            misalign_o = 1'b0;
        end
    end

    assign bus_addr_o  = r_bus_addr;
    assign bus_wdata_o = r_bus_wdata;
    assign bus_sel_o   = r_bus_sel;
    assign bus_we_o    = r_bus_we;
    assign bus_cyc_o   = r_bus_cyc;
    assign bus_err_o   = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_bus_ctrl
// Brief   : Directed self-checking bench for mem_bus_ctrl (timeout set to 4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_bus_ctrl;

    localparam logic [7:0] C_OP_ADDU = 8'b0010_0001;
    localparam logic [7:0] C_OP_LB   = 8'b1110_0000;
    localparam logic [7:0] C_OP_LH   = 8'b1110_0001;
    localparam logic [7:0] C_OP_LW   = 8'b1110_0011;
    localparam logic [7:0] C_OP_LBU  = 8'b1110_0100;
    localparam logic [7:0] C_OP_LHU  = 8'b1110_0101;
    localparam logic [7:0] C_OP_SH   = 8'b1110_1001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wdata_i, hi_i, lo_i, mem_addr_i, reg2_i, bus_rdata_i;
    logic [4:0]  wd_i;
    logic        wreg_i, whilo_i, stall_i, bus_ack_i;
    logic [7:0]  aluop_i;
    logic [31:0] wdata_o, hi_o, lo_o, bus_addr_o, bus_wdata_o;
    logic [4:0]  wd_o;
    logic        wreg_o, whilo_o, bus_we_o, bus_cyc_o, stallreq_o, misalign_o, bus_err_o;
    logic [3:0]  bus_sel_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_cyc;

    mem_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wdata_i(wdata_i), .wd_i(wd_i), .wreg_i(wreg_i), .whilo_i(whilo_i),
        .hi_i(hi_i), .lo_i(lo_i), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
        .reg2_i(reg2_i), .stall_i(stall_i), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
        .wdata_o(wdata_o), .wd_o(wd_o), .wreg_o(wreg_o), .whilo_o(whilo_o),
        .hi_o(hi_o), .lo_o(lo_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_sel_o(bus_sel_o), .bus_we_o(bus_we_o), .bus_cyc_o(bus_cyc_o),
        .stallreq_o(stallreq_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] st);
        aluop_i    = op;
        mem_addr_i = addr;
        reg2_i     = st;
        #1;
    endtask

    // Called on the first BUSY cycle; acks on BUSY cycle n and returns in DONE
    task automatic ack_on(input int n, input logic [31:0] rdata);
        for (int i = 1; i < n; i++) tick();
        bus_ack_i   = 1'b1;
        bus_rdata_i = rdata;
        tick();
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; stall_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        wdata_i = 32'h1111_2222; wd_i = 5'd7; wreg_i = 1'b1; whilo_i = 1'b1;
        hi_i = 32'hAAAA_0001; lo_i = 32'hBBBB_0002;
        set_op(C_OP_ADDU, 32'h0, 32'h0);
        tick();
        chk("rst_wdata", wdata_o, 32'h0);
        chk("rst_wreg", {31'h0, wreg_o}, 32'h0);
        chk("rst_hi", hi_o, 32'h0);
        chk("rst_cyc_stall", {30'h0, bus_cyc_o, stallreq_o}, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("addu_wdata", wdata_o, 32'h1111_2222);
        chk("addu_ctrl", {wd_o, wreg_o, whilo_o}, {5'd7, 1'b1, 1'b1});
        chk("addu_hilo", hi_o ^ lo_o, 32'hAAAA_0001 ^ 32'hBBBB_0002);
        chk("addu_stall", {31'h0, stallreq_o}, 32'h0);

        // LW 0x100, ack on 2nd BUSY cycle
        tick();
        set_op(C_OP_LW, 32'h100, 32'h0);
        chk("lw_idle_stall", {30'h0, stallreq_o, bus_cyc_o}, 32'h2);
        tick();
        chk("lw_busy_bus", {bus_addr_o[15:0], 8'h0, bus_sel_o, 2'b0, bus_we_o, bus_cyc_o},
            {16'h0100, 8'h0, 4'hF, 2'b0, 1'b0, 1'b1});
        chk("lw_busy1_stall", {31'h0, stallreq_o}, 32'h1);
        tick();
        chk("lw_busy2_stall", {31'h0, stallreq_o}, 32'h1);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h89AB_CDEF;
        tick();
        bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        chk("lw_done_ctrl", {29'h0, bus_cyc_o, stallreq_o, wreg_o}, 32'h1);
        chk("lw_done_data", wdata_o, 32'h89AB_CDEF);
        stall_i = 1'b1;
        tick();
        chk("lw_hold_data", wdata_o, 32'h89AB_CDEF);
        chk("lw_hold_stall", {31'h0, stallreq_o}, 32'h0);
        stall_i = 1'b0;
        tick();

        // LB / LBU 0x103
        set_op(C_OP_LB, 32'h103, 32'h0);
        tick();
        chk("lb_sel", {28'h0, bus_sel_o}, 32'h1);
        ack_on(1, 32'h0000_00F0);
        chk("lb_data", wdata_o, 32'hFFFF_FFF0);
        tick();
        set_op(C_OP_LBU, 32'h103, 32'h0);
        tick();
        ack_on(1, 32'h0000_00F0);
        chk("lbu_data", wdata_o, 32'h0000_00F0);
        tick();

        // LH 0x200 sign-extends upper half
        set_op(C_OP_LH, 32'h200, 32'h0);
        tick();
        chk("lh_sel", {28'h0, bus_sel_o}, 32'hC);
        ack_on(3, 32'h8001_0000);
        chk("lh_data", wdata_o, 32'hFFFF_8001);
        tick();

        // SH 0x202
        set_op(C_OP_SH, 32'h202, 32'h1234_ABCD);
        tick();
        chk("sh_bus", {bus_sel_o, 3'b0, bus_we_o, 8'h0, bus_wdata_o[15:0]}, {4'h3, 3'b0, 1'b1, 8'h0, 16'hABCD});
        chk("sh_addr", bus_addr_o, 32'h200);
        ack_on(1, 32'h0);
        chk("sh_done_wreg", {31'h0, wreg_o}, 32'h0);
        tick();

        // Misaligned LW 0x101
        set_op(C_OP_LW, 32'h101, 32'h0);
        chk("mis_flags", {29'h0, misalign_o, stallreq_o, wreg_o}, 32'h4);
        tick();
        chk("mis_nocyc", {31'h0, bus_cyc_o}, 32'h0);
        set_op(C_OP_ADDU, 32'h0, 32'h0);
        chk("mis_pulse_end", {31'h0, misalign_o}, 32'h0);

        // Ack while IDLE is ignored
        bus_ack_i = 1'b1;
        tick();
        bus_ack_i = 1'b0;
        chk("idle_ack_ignored", {31'h0, bus_cyc_o}, 32'h0);

        // Timeout with no ack
        set_op(C_OP_LH, 32'h204, 32'h0);
        n_cyc = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_cyc_o) n_cyc++;
            else break;
        end
        chk("to_cyc_count", n_cyc, 32'd4);
        chk("to_err_pulse", {30'h0, bus_err_o, wreg_o}, 32'h2);
        chk("to_data", wdata_o, 32'h0);
        stall_i = 1'b1;
        tick();
        chk("to_err_end", {30'h0, bus_err_o, stallreq_o}, 32'h0);
        stall_i = 1'b0;
        tick();

        // Error flag cleared for the next access
        set_op(C_OP_LHU, 32'h206, 32'h0);
        tick();
        ack_on(2, 32'h1234_BEEF);
        chk("lhu_after_to", wdata_o, 32'h0000_BEEF);
        chk("lhu_after_to_wreg", {31'h0, wreg_o}, 32'h1);
        tick();

        // Reset during BUSY
        set_op(C_OP_LW, 32'h300, 32'h0);
        tick();
        chk("rstm_busy", {31'h0, bus_cyc_o}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rstm_cyc_drop", {30'h0, bus_cyc_o, stallreq_o}, 32'h0);
        chk("rstm_wdata", wdata_o, 32'h0);
        tick();
        rst_n = 1'b1;
        wdata_i = 32'h5555_6666; wd_i = 5'd12;
        set_op(C_OP_ADDU, 32'h0, 32'h0);
        chk("post_rst_addu", wdata_o, 32'h5555_6666);
        chk("post_rst_ctrl", {wd_o, wreg_o, stallreq_o}, {5'd12, 1'b1, 1'b0});
        tick();
        chk("post_rst_idle", {31'h0, bus_cyc_o}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
